// File: rtl/transpose_pingpong_ctrl.sv
// Ping-pong transpose RAM controller: fills one bank row-major from the input stream
// while the other, already full bank is read column-major and streamed out.
module transpose_pingpong_ctrl #(
    parameter int DATA_WIDTH = 10,
    parameter int N          = 8,
    localparam int AW        = $clog2(2*N*N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int            CW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX   = CW'(N - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [AW-1:0] BANK_OFS   = AW'(N * N);
    localparam logic [AW-1:0] ROW_STRIDE = AW'(N);

    typedef enum logic {IDLE, READ} rstate_t;

    rstate_t       rstate_reg, rstate_next;
    logic          wsel_reg, wsel_next;
    logic          rsel_reg, rsel_next;
    logic [1:0]    bank_full_reg, bank_full_next;
    logic [1:0]    bank_set, bank_clr;
    logic [CW-1:0] wr_reg, wr_next, wc_reg, wc_next;
    logic [CW-1:0] rr_reg, rr_next, rc_reg, rc_next;
    logic          out_valid_reg, out_valid_next;
    logic          out_last_reg, out_last_next;
    logic          wr_fire, wr_last, rd_fire, rd_last;

    // Write side is purely combinational off the registered bank flags.
    assign in_ready = !bank_full_reg[wsel_reg];
    assign wr_fire  = in_valid & in_ready;
    assign wr_last  = (wr_reg == LAST_IDX) && (wc_reg == LAST_IDX);
    assign wr_en    = wr_fire;
    assign wr_data  = in_data;
    assign wr_addr  = (wsel_reg ? BANK_OFS : '0) + AW'(wr_reg) * ROW_STRIDE + AW'(wc_reg);

    // A new read is issued only when the output register is empty or draining.
    assign rd_fire  = (rstate_reg == READ) && (!out_valid_reg || out_ready);
    assign rd_last  = (rr_reg == LAST_IDX) && (rc_reg == LAST_IDX);
    assign rd_en    = rd_fire;
    assign rd_addr  = (rsel_reg ? BANK_OFS : '0) + AW'(rr_reg) * ROW_STRIDE + AW'(rc_reg);

    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_data  = rd_data;

    // Writer and reader always touch different banks, so set and clear never collide.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_set[gi]       = wr_fire && wr_last && (wsel_reg == 1'(gi));
            assign bank_clr[gi]       = rd_fire && rd_last && (rsel_reg == 1'(gi));
            assign bank_full_next[gi] = (bank_full_reg[gi] | bank_set[gi]) & ~bank_clr[gi];
        end
    endgenerate

    always_comb begin
        wr_next   = wr_reg;
        wc_next   = wc_reg;
        wsel_next = wsel_reg;
        if (wr_fire) begin
            if (wr_last) begin
                wr_next   = '0;
                wc_next   = '0;
                wsel_next = !wsel_reg;
            end else if (wc_reg == LAST_IDX) begin
                wc_next = '0;
                wr_next = wr_reg + ONE;
            end else begin
                wc_next = wc_reg + ONE;
            end
        end
    end

    always_comb begin
        rstate_next    = rstate_reg;
        rr_next        = rr_reg;
        rc_next        = rc_reg;
        rsel_next      = rsel_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;

        // Looking at the updated flags lets a block written this very cycle follow without a bubble.
        case (rstate_reg)
            IDLE:    if (bank_full_reg[rsel_reg]) rstate_next = READ;
            READ:    if (rd_fire && rd_last) rstate_next = bank_full_next[!rsel_reg] ? READ : IDLE;
            default: rstate_next = IDLE;
        endcase

        if (rd_fire) begin
            out_valid_next = 1'b1;
            out_last_next  = rd_last;
            if (rd_last) begin
                rr_next   = '0;
                rc_next   = '0;
                rsel_next = !rsel_reg;
            end else if (rr_reg == LAST_IDX) begin
                rr_next = '0;
                rc_next = rc_reg + ONE;
            end else begin
                rr_next = rr_reg + ONE;
            end
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_reg    <= IDLE;
            wsel_reg      <= 1'b0;
            rsel_reg      <= 1'b0;
            bank_full_reg <= 2'b00;
            wr_reg        <= '0;
            wc_reg        <= '0;
            rr_reg        <= '0;
            rc_reg        <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            rstate_reg    <= rstate_next;
            wsel_reg      <= wsel_next;
            rsel_reg      <= rsel_next;
            bank_full_reg <= bank_full_next;
            wr_reg        <= wr_next;
            wc_reg        <= wc_next;
            rr_reg        <= rr_next;
            rc_reg        <= rc_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
        end
    end

endmodule

// File: tb/tb_transpose_pingpong_ctrl.sv
// Bench for transpose_pingpong_ctrl: RAM model plus a block-level reference that tracks
// written samples, issued reads and consumed outputs as plain counters and queues.
module tb_transpose_pingpong_ctrl;

    localparam int DW  = 10;
    localparam int N   = 8;
    localparam int BLK = N * N;
    localparam int AW  = $clog2(2 * N * N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    transpose_pingpong_ctrl #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready)
    );

    // Dual-port RAM: read data appears one cycle after rd_en and holds otherwise.
    logic [DW-1:0] mem [0:2*BLK-1];
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    logic [DW-1:0] pend[$];
    logic [DW-1:0] sent[$];
    int ri, oi, cyc;
    int total = 0;
    int bad = 0;
    int blk_wr_start [32];
    int blk_wr_done  [32];
    int blk_rd_start [32];
    int blk_rd_done  [32];
    int blk_out_start[32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Position in the transposed stream -> bank address / source sample index.
    function automatic int rd_addr_of(input int idx);
        int b, k;
        b = idx / BLK;
        k = idx % BLK;
        return (b % 2) * BLK + (k % N) * N + k / N;
    endfunction

    function automatic int src_of(input int idx);
        int b, k;
        b = idx / BLK;
        k = idx % BLK;
        return b * BLK + (k % N) * N + k / N;
    endfunction

    task automatic clear_model();
        pend.delete();
        sent.delete();
        ri = 0;
        oi = 0;
        for (int i = 0; i < 32; i++) begin
            blk_wr_start[i]  = -1;
            blk_wr_done[i]   = -1;
            blk_rd_start[i]  = -1;
            blk_rd_done[i]   = -1;
            blk_out_start[i] = -1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_addr", rd_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at negedge, check combinational/registered outputs, advance model.
    task automatic cycle(input bit iv, input bit ordy);
        int  wb, b, src;
        bit  exp_rdy, exp_ov, wfire;
        @(negedge clk);
        in_valid  = iv && (pend.size() > 0);
        in_data   = (pend.size() > 0) ? pend[0] : '0;
        out_ready = ordy;
        #1;
        wb      = sent.size() / BLK;
        exp_rdy = (wb - ri / BLK) < 2;
        exp_ov  = (ri != oi);
        chk("in_ready", in_ready, exp_rdy);
        chk("wr_en", wr_en, in_valid && exp_rdy);
        chk("out_valid", out_valid, exp_ov);
        wfire = wr_en && in_valid && (pend.size() > 0);
        if (wfire) begin
            chk("wr_addr", wr_addr, (wb % 2) * BLK + sent.size() % BLK);
            chk("wr_data", wr_data, pend[0]);
        end
        if (out_valid && exp_ov) begin
            src = src_of(oi);
            if (src < sent.size()) chk("out_data", out_data, sent[src]);
            chk("out_last", out_last, (oi % BLK) == BLK - 1);
        end
        if (rd_en) begin
            chk("rd_avail", (ri / BLK) < wb, 1);
            chk("rd_hold", out_valid && !out_ready, 0);
            chk("rd_addr", rd_addr, rd_addr_of(ri));
        end

        if (wfire) begin
            b = sent.size() / BLK;
            if (sent.size() % BLK == 0 && b < 32) blk_wr_start[b] = cyc;
            sent.push_back(pend.pop_front());
            if (sent.size() % BLK == 0 && b < 32) blk_wr_done[b] = cyc;
        end
        if (out_valid && exp_ov) begin
            b = oi / BLK;
            if (oi % BLK == 0 && b < 32 && blk_out_start[b] == -1) blk_out_start[b] = cyc;
            if (out_ready) oi++;
        end
        if (rd_en) begin
            b = ri / BLK;
            if (ri % BLK == 0 && b < 32) blk_rd_start[b] = cyc;
            ri++;
            if (ri % BLK == 0 && b < 32) blk_rd_done[b] = cyc;
        end
        cyc++;
    endtask

    task automatic push_random(input int count);
        for (int i = 0; i < count; i++) pend.push_back(DW'($urandom));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pend.size() > 0 || oi < sent.size()) && n < budget) begin
            cycle(1, 1);
            n++;
        end
        chk("drain_pending", pend.size(), 0);
        chk("drain_out_count", oi, sent.size());
        repeat (3) cycle(0, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cyc = 0;

        // 1: reset, then reset again in the middle of a block
        do_reset();
        for (int i = 0; i < BLK; i++) pend.push_back(DW'(i));
        repeat (20) cycle(1, 1);
        chk("mid_block_sent", sent.size(), 20);
        do_reset();

        // 2: single block 0..63, checks transpose order and latency
        for (int i = 0; i < BLK; i++) pend.push_back(DW'(i));
        drain(400);
        chk("lat_rd_en", blk_rd_start[0] - blk_wr_done[0], 2);
        chk("lat_out_valid", blk_out_start[0] - blk_wr_done[0], 3);

        // 3: four blocks streamed back-to-back
        do_reset();
        push_random(4 * BLK);
        drain(1000);
        for (int b = 0; b < 3; b++) chk("stream_contiguous", blk_out_start[b+1] - blk_out_start[b], BLK);

        // 4: output backpressure during block 0 read
        do_reset();
        push_random(3 * BLK);
        n = 0;
        while (ri == 0 && n < 300) begin
            cycle(1, 1);
            n++;
        end
        repeat (200) cycle(1, 0);
        chk("bp_data_frozen", out_data, sent[0]);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_bank1_filled", sent.size(), 2 * BLK);
        n = 0;
        while (ri < BLK && n < 300) begin
            cycle(1, 1);
            n++;
        end
        drain(1000);
        chk("bp_resume", blk_wr_start[2] - blk_rd_done[0], 1);

        // 6: last write of bank 1 coincides with last read issue of bank 0
        do_reset();
        push_random(2 * BLK);
        n = 0;
        while (sent.size() < 2 * BLK - 1 && n < 300) begin
            cycle(1, 1);
            n++;
        end
        n = 0;
        while (ri < BLK - 1 && n < 300) begin
            cycle(0, 1);
            n++;
        end
        cycle(1, 1);
        chk("sim_same_cycle", blk_wr_done[1], blk_rd_done[0]);
        cycle(0, 1);
        chk("sim_in_ready", in_ready, 1);
        drain(400);
        chk("sim_no_bubble", blk_rd_start[1] - blk_rd_done[0], 1);

        // 5: random valid/ready over 20 blocks
        do_reset();
        push_random(20 * BLK);
        n = 0;
        while (oi < 20 * BLK && n < 20000) begin
            cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));
            n++;
        end
        chk("rand_all_out", oi, 20 * BLK);
        drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
